// File: rtl/myrisc16_loader.sv
// Boot loader for myrisc16: turns a framed byte stream into memory word writes, then releases the core.
// Build option: define MYRISC16_LOADER_CHECKSUM_EN to add the trailing checksum check and the ERR state.
module myrisc16_loader #(
   parameter logic [7:0] MAGIC  = 8'hA5,
   parameter int         ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_rstn,
   output logic              done,
   output logic              error
);

`ifdef MYRISC16_LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L,
      S_CSUM_H, S_CSUM_L, S_FINISH, S_RUN, S_ERR
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L,
      S_FINISH, S_RUN
   } state_t;
`endif

   state_t              r_state, w_next, w_end;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_cnt;
   logic [7:0]          r_hi;
   logic                r_we;
   logic [ADDR_W-1:0]   r_maddr;
   logic [15:0]         r_wdata;
   logic                w_acc;
   logic [15:0]         w_cnt_new;
   logic [15:0]         w_word;
`ifdef MYRISC16_LOADER_CHECKSUM_EN
   logic [15:0]         r_sum;
   logic [7:0]          r_csum_hi;
`endif

   assign w_acc     = in_valid && in_ready;
   assign w_cnt_new = {r_cnt[15:8], in_data};
   assign w_word    = {r_hi, in_data};

`ifdef MYRISC16_LOADER_CHECKSUM_EN
   assign w_end    = S_CSUM_H;
   assign in_ready = !(r_state == S_FINISH || r_state == S_RUN || r_state == S_ERR);
   assign error    = (r_state == S_ERR);
`else
   assign w_end    = S_FINISH;
   assign in_ready = !(r_state == S_FINISH || r_state == S_RUN);
   assign error    = 1'b0;
`endif

   // The core is released only once the final write has had its FINISH cycle.
   assign cpu_rstn  = (r_state == S_RUN);
   assign done      = (r_state == S_RUN);
   assign mem_we    = r_we;
   assign mem_addr  = r_maddr;
   assign mem_wdata = r_wdata;

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_acc && in_data == MAGIC) w_next = S_ADDR_H;
         S_ADDR_H: if (w_acc) w_next = S_ADDR_L;
         S_ADDR_L: if (w_acc) w_next = S_CNT_H;
         S_CNT_H:  if (w_acc) w_next = S_CNT_L;
         S_CNT_L:  if (w_acc) w_next = (w_cnt_new == 16'd0) ? w_end : S_DATA_H;
         S_DATA_H: if (w_acc) w_next = S_DATA_L;
         S_DATA_L: if (w_acc) w_next = (r_cnt == 16'd1) ? w_end : S_DATA_H;
`ifdef MYRISC16_LOADER_CHECKSUM_EN
         S_CSUM_H: if (w_acc) w_next = S_CSUM_L;
         S_CSUM_L: if (w_acc) w_next = ({r_csum_hi, in_data} == r_sum) ? S_FINISH : S_ERR;
         S_ERR:    w_next = S_ERR;
`endif
         S_FINISH: w_next = S_RUN;
         S_RUN:    w_next = S_RUN;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_addr    <= '0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_we      <= 1'b0;
         r_maddr   <= '0;
         r_wdata   <= '0;
`ifdef MYRISC16_LOADER_CHECKSUM_EN
         r_sum     <= '0;
         r_csum_hi <= '0;
`endif
      end else begin
         r_we <= 1'b0;
`ifdef MYRISC16_LOADER_CHECKSUM_EN
         if (r_state == S_IDLE) r_sum <= '0;
`endif
         if (w_acc) begin
            case (r_state)
               S_ADDR_H: r_addr[ADDR_W-1:8] <= in_data;
               S_ADDR_L: r_addr[7:0]        <= in_data;
               S_CNT_H:  r_cnt[15:8]        <= in_data;
               S_CNT_L:  r_cnt[7:0]         <= in_data;
               S_DATA_H: r_hi               <= in_data;
               S_DATA_L: begin
                  r_we    <= 1'b1;
                  r_maddr <= r_addr;
                  r_wdata <= w_word;
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_cnt   <= r_cnt - 16'd1;
`ifdef MYRISC16_LOADER_CHECKSUM_EN
                  r_sum   <= r_sum + w_word;
`endif
               end
`ifdef MYRISC16_LOADER_CHECKSUM_EN
               S_CSUM_H: r_csum_hi <= in_data;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_myrisc16_loader.sv
// Directed bench for myrisc16_loader: framing, writes, wrap, sync discard, mid-frame reset, checksum.
module tb_myrisc16_loader;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_we, cpu_rstn, done, error;
   logic [15:0] mem_addr, mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [15:0] wa[$];
   logic [15:0] wd[$];
   int          wc[$];

   myrisc16_loader dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rstn(cpu_rstn), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
   end

   task automatic do_reset();
      rstn = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1; in_data = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_slow(input logic [7:0] b);
      send(b);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rstn got %b want 0", cpu_rstn); end
      n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_tests++; if (mem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_tests++; if (error !== 1'b0)    begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
      n_tests++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0)
         begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0000/0000", mem_addr, mem_wdata); end
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_tests++; if (cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL idle_cpu_rstn got %b want 0", cpu_rstn); end
   endtask

   task automatic test_basic();
      logic [7:0] fr[9] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      int b;
      do_reset();
      b = wa.size();
      for (int i = 0; i < 9; i++) send(fr[i]);
      // one cycle after the CD edge: FINISH with the last write on the bus
      n_tests++; if (mem_we !== 1'b1 || mem_addr !== 16'h0011 || mem_wdata !== 16'hABCD)
         begin n_fail++; $display("FAIL basic_last_write got we=%b %h=%h want 1 0011=abcd", mem_we, mem_addr, mem_wdata); end
      n_tests++; if (in_ready !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL basic_finish got ready=%b done=%b want 0 0", in_ready, done); end
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b1 || cpu_rstn !== 1'b1)
         begin n_fail++; $display("FAIL basic_done got done=%b cpu_rstn=%b want 1 1", done, cpu_rstn); end
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got %b want 0", error); end
      n_tests++;
      if (wa.size() != b + 2) begin n_fail++; $display("FAIL basic_nwrites got %0d want 2", wa.size() - b); end
      else if (wa[b] !== 16'h0010 || wd[b] !== 16'h1234 || wa[b+1] !== 16'h0011 || wd[b+1] !== 16'hABCD ||
               wc[b+1] - wc[b] < 2) begin
         n_fail++;
         $display("FAIL basic_writes got %h=%h %h=%h gap %0d want 0010=1234 0011=abcd gap>=2",
                  wa[b], wd[b], wa[b+1], wd[b+1], wc[b+1] - wc[b]);
      end
      // RUN ignores further traffic
      send(8'hA5); send(8'h00); repeat (4) @(posedge clk); #1;
      n_tests++; if (wa.size() != b + 2 || done !== 1'b1 || in_ready !== 1'b0)
         begin n_fail++; $display("FAIL run_ignore got writes=%0d done=%b ready=%b want 2 1 0", wa.size() - b, done, in_ready); end
   endtask

   task automatic test_sync_zero();
      logic [7:0] fr[8] = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      int b;
      do_reset();
      b = wa.size();
      for (int i = 0; i < 8; i++) send(fr[i]);
      n_tests++; if (in_ready !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL zero_finish got ready=%b done=%b want 0 0", in_ready, done); end
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b1 || cpu_rstn !== 1'b1 || wa.size() != b)
         begin n_fail++; $display("FAIL zero_done got done=%b cpu=%b writes=%0d want 1 1 0", done, cpu_rstn, wa.size() - b); end
      do_reset();
      b = wa.size();
      for (int i = 0; i < 8; i++) send_slow(fr[i]);
      n_tests++; if (done !== 1'b1 || cpu_rstn !== 1'b1 || wa.size() != b)
         begin n_fail++; $display("FAIL zero_slow got done=%b cpu=%b writes=%0d want 1 1 0", done, cpu_rstn, wa.size() - b); end
   endtask

   task automatic test_wrap();
      logic [7:0] fr[9] = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
      int b;
      do_reset();
      b = wa.size();
      for (int i = 0; i < 9; i++) send(fr[i]);
      repeat (2) @(posedge clk); #1;
      n_tests++;
      if (wa.size() != b + 2) begin n_fail++; $display("FAIL wrap_nwrites got %0d want 2", wa.size() - b); end
      else if (wa[b] !== 16'hFFFF || wd[b] !== 16'h1111 || wa[b+1] !== 16'h0000 || wd[b+1] !== 16'h2222) begin
         n_fail++;
         $display("FAIL wrap_writes got %h=%h %h=%h want ffff=1111 0000=2222", wa[b], wd[b], wa[b+1], wd[b+1]);
      end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
   endtask

   task automatic test_mid_reset();
      logic [7:0] fa[7] = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h03, 8'h55, 8'h66};
      logic [7:0] fb[7] = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'h77, 8'h88};
      int b;
      do_reset();
      b = wa.size();
      for (int i = 0; i < 7; i++) send(fa[i]);
      rstn = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (cpu_rstn !== 1'b0 || in_ready !== 1'b1 || mem_we !== 1'b0)
         begin n_fail++; $display("FAIL midrst_outputs got cpu=%b ready=%b we=%b want 0 1 0", cpu_rstn, in_ready, mem_we); end
      rstn = 1'b1;
      repeat (2) @(posedge clk); #1;
      n_tests++;
      if (wa.size() != b + 1) begin n_fail++; $display("FAIL midrst_nwrites got %0d want 1", wa.size() - b); end
      else if (wa[b] !== 16'h0020 || wd[b] !== 16'h5566) begin
         n_fail++; $display("FAIL midrst_write got %h=%h want 0020=5566", wa[b], wd[b]);
      end
      for (int i = 0; i < 7; i++) send(fb[i]);
      @(posedge clk); #1;
      n_tests++;
      if (wa.size() != b + 2 || done !== 1'b1) begin
         n_fail++; $display("FAIL midrst_reload got writes=%0d done=%b want 2 1", wa.size() - b, done);
      end else if (wa[b+1] !== 16'h0030 || wd[b+1] !== 16'h7788) begin
         n_fail++; $display("FAIL midrst_reload_write got %h=%h want 0030=7788", wa[b+1], wd[b+1]);
      end
   endtask

`ifdef MYRISC16_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] fr[11] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
      do_reset();
      for (int i = 0; i < 11; i++) send(fr[i]);
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b1 || error !== 1'b0 || cpu_rstn !== 1'b1)
         begin n_fail++; $display("FAIL csum_ok got done=%b err=%b cpu=%b want 1 0 1", done, error, cpu_rstn); end
      do_reset();
      fr[10] = 8'h02;
      for (int i = 0; i < 11; i++) send(fr[i]);
      repeat (3) @(posedge clk); #1;
      n_tests++; if (error !== 1'b1 || done !== 1'b0 || cpu_rstn !== 1'b0 || in_ready !== 1'b0)
         begin n_fail++; $display("FAIL csum_bad got err=%b done=%b cpu=%b ready=%b want 1 0 0 0", error, done, cpu_rstn, in_ready); end
      do_reset();
      #1;
      n_tests++; if (error !== 1'b0 || in_ready !== 1'b1)
         begin n_fail++; $display("FAIL csum_clear got err=%b ready=%b want 0 1", error, in_ready); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_sync_zero();
      test_wrap();
      test_mid_reset();
`ifdef MYRISC16_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
